// File: rtl/cmps2_uart_cmd.sv
// Host-side UART command receiver for the Pmod CMPS2 interface: deserialises 8N1
// bytes and turns single-byte commands into measure/calibrate pulses and a resolution.
module cmps2_uart_cmd #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         TIMEOUT_CYC  = 10_000_000,
    parameter logic [1:0] RES_DEFAULT  = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       valid,
    output logic       measure,
    output logic       calibrate,
    output logic [1:0] resolution,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       cmd_error,
    output logic       frame_error
);
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int TCW = $clog2(TIMEOUT_CYC);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_RECOVER} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_RES_ARG, P_WAIT} p_state_t;

    rx_state_t      rstate_q, rstate_d;
    p_state_t       pstate_q, pstate_d;
    logic           rx_meta_q, rx_sync_q, valid_q;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_strobe_q, rx_strobe_d;
    logic           frame_error_q, frame_error_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [1:0]     resolution_q, resolution_d;
    logic           measure_q, measure_d;
    logic           calibrate_q, calibrate_d;
    logic           cmd_error_q, cmd_error_d;
    logic           busy_q, busy_d;
    logic           valid_edge;

    assign valid_edge = valid & ~valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            valid_q       <= 1'b0;
            rstate_q      <= R_IDLE;
            pstate_q      <= P_IDLE;
            bcnt_q        <= '0;
            bidx_q        <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_strobe_q   <= 1'b0;
            frame_error_q <= 1'b0;
            tcnt_q        <= '0;
            resolution_q  <= RES_DEFAULT;
            measure_q     <= 1'b0;
            calibrate_q   <= 1'b0;
            cmd_error_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            valid_q       <= valid;
            rstate_q      <= rstate_d;
            pstate_q      <= pstate_d;
            bcnt_q        <= bcnt_d;
            bidx_q        <= bidx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_strobe_q   <= rx_strobe_d;
            frame_error_q <= frame_error_d;
            tcnt_q        <= tcnt_d;
            resolution_q  <= resolution_d;
            measure_q     <= measure_d;
            calibrate_q   <= calibrate_d;
            cmd_error_q   <= cmd_error_d;
            busy_q        <= busy_d;
        end
    end

    // Receiver: start bit re-checked at mid-bit, then every later sample lands mid-bit.
    always_comb begin
        rstate_d      = rstate_q;
        bcnt_d        = bcnt_q;
        bidx_d        = bidx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_strobe_d   = 1'b0;
        frame_error_d = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (!rx_sync_q) begin
                    rstate_d = R_START;
                    bcnt_d   = '0;
                    bidx_d   = '0;
                end
            end
            R_START: begin
                if (bcnt_q == HALF_LAST) begin
                    bcnt_d   = '0;
                    rstate_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d  = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) rstate_d = R_STOP;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d = '0;
                    if (rx_sync_q) begin
                        rx_data_d   = shift_q;
                        rx_strobe_d = 1'b1;
                        rstate_d    = R_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        rstate_d      = R_RECOVER;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            R_RECOVER: begin
                if (rx_sync_q) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Command parser; a valid edge always beats a coincident timeout.
    always_comb begin
        pstate_d     = pstate_q;
        tcnt_d       = tcnt_q;
        resolution_d = resolution_q;
        measure_d    = 1'b0;
        calibrate_d  = 1'b0;
        cmd_error_d  = 1'b0;
        case (pstate_q)
            P_IDLE: begin
                if (rx_strobe_q) begin
                    case (rx_data_q)
                        8'h4D: begin
                            measure_d = 1'b1;
                            tcnt_d    = '0;
                            pstate_d  = P_WAIT;
                        end
                        8'h43: begin
                            calibrate_d = 1'b1;
                            tcnt_d      = '0;
                            pstate_d    = P_WAIT;
                        end
                        8'h52:   pstate_d    = P_RES_ARG;
                        default: cmd_error_d = 1'b1;
                    endcase
                end
            end
            P_RES_ARG: begin
                if (frame_error_q) begin
                    pstate_d = P_IDLE;
                end else if (rx_strobe_q) begin
                    if (rx_data_q[7:2] == 6'd0) resolution_d = rx_data_q[1:0];
                    else                        cmd_error_d  = 1'b1;
                    pstate_d = P_IDLE;
                end
            end
            P_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                if (rx_strobe_q) cmd_error_d = 1'b1;
                if (valid_edge) begin
                    pstate_d = P_IDLE;
                end else if (tcnt_q == TMO_LAST) begin
                    cmd_error_d = 1'b1;
                    pstate_d    = P_IDLE;
                end
            end
            default: pstate_d = P_IDLE;
        endcase
        busy_d = (pstate_d == P_WAIT);
    end

    assign measure     = measure_q;
    assign calibrate   = calibrate_q;
    assign resolution  = resolution_q;
    assign busy        = busy_q;
    assign rx_data     = rx_data_q;
    assign rx_strobe   = rx_strobe_q;
    assign cmd_error   = cmd_error_q;
    assign frame_error = frame_error_q;
endmodule

// File: tb/tb_cmps2_uart_cmd.sv
// Scoreboard bench for cmps2_uart_cmd: stimulus queues expected output pulses,
// a negedge monitor pops and compares them with cycle spacing where it matters.
module tb_cmps2_uart_cmd;
    localparam int CPB = 16;
    localparam int TMO = 1000;
    localparam int K_STB = 0, K_FE = 1, K_MEAS = 2, K_CAL = 3, K_CERR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       valid = 1'b0;
    logic       measure, calibrate, busy, rx_strobe, cmd_error, frame_error;
    logic [1:0] resolution;
    logic [7:0] rx_data;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         dt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   meas_cyc = 0;
    bit   meas_seen = 1'b0;

    cmps2_uart_cmd #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TMO), .RES_DEFAULT(2'b00)) dut (
        .clk(clk), .rst(rst), .rx(rx), .valid(valid),
        .measure(measure), .calibrate(calibrate), .resolution(resolution), .busy(busy),
        .rx_data(rx_data), .rx_strobe(rx_strobe), .cmd_error(cmd_error),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void expect_evt(int kind, logic [7:0] data, int dt);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.dt   = dt;
        q.push_back(e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic sb_pop(int kind, logic [7:0] data);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got event kind %0d (data 0x%0h) at cycle %0d, required none",
                     kind, data, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind == K_STB && e.data != data) ||
                (e.dt >= 0 && (cyc - last_cyc) != e.dt)) begin
                errors++;
                $display("FAIL sb_event: got kind %0d data 0x%0h dt %0d, required kind %0d data 0x%0h dt %0d",
                         kind, data, cyc - last_cyc, e.kind, e.data, e.dt);
            end
        end
        last_cyc = cyc;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rx_strobe)   sb_pop(K_STB, rx_data);
            if (frame_error) sb_pop(K_FE, 8'h00);
            if (measure) begin
                meas_seen = 1'b1;
                meas_cyc  = cyc;
                sb_pop(K_MEAS, 8'h00);
            end
            if (calibrate)   sb_pop(K_CAL, 8'h00);
            if (cmd_error)   sb_pop(K_CERR, 8'h00);
        end
    end

    task automatic hold_bit(logic b);
        @(negedge clk) rx = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] b, logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        @(negedge clk) rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_valid_check(string name);
        @(negedge clk) valid = 1'b1;
        @(negedge clk);
        chk(name, {31'd0, busy}, 32'd0);
        valid = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_measure"}, {31'd0, measure}, 32'd0);
        chk({tag, "_calibrate"}, {31'd0, calibrate}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rx_strobe"}, {31'd0, rx_strobe}, 32'd0);
        chk({tag, "_cmd_error"}, {31'd0, cmd_error}, 32'd0);
        chk({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'h00);
        chk({tag, "_resolution"}, {30'd0, resolution}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: measure, valid 50 cycles after the pulse
        expect_evt(K_STB, 8'h4D, -1);
        expect_evt(K_MEAS, 8'h00, 1);
        meas_seen = 1'b0;
        send_frame(8'h4D, 1'b1);
        n = 0;
        while (!(meas_seen && cyc >= meas_cyc + 50) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t1_measure_seen", {31'd0, meas_seen}, 32'd1);
        chk("t1_busy_before_valid", {31'd0, busy}, 32'd1);
        valid = 1'b1;
        @(negedge clk);
        chk("t1_busy_after_valid", {31'd0, busy}, 32'd0);
        valid = 1'b0;
        repeat (5) @(negedge clk);

        // 2: resolution set, then rejected argument
        expect_evt(K_STB, 8'h52, -1);
        expect_evt(K_STB, 8'h02, -1);
        send_frame(8'h52, 1'b1);
        send_frame(8'h02, 1'b1);
        chk("t2_resolution_set", {30'd0, resolution}, 32'd2);
        expect_evt(K_STB, 8'h52, -1);
        expect_evt(K_STB, 8'h07, -1);
        expect_evt(K_CERR, 8'h00, 1);
        send_frame(8'h52, 1'b1);
        send_frame(8'h07, 1'b1);
        repeat (3) @(negedge clk);
        chk("t2_resolution_kept", {30'd0, resolution}, 32'd2);

        // 3: calibrate with no valid -> timeout
        expect_evt(K_STB, 8'h43, -1);
        expect_evt(K_CAL, 8'h00, 1);
        expect_evt(K_CERR, 8'h00, TMO);
        send_frame(8'h43, 1'b1);
        chk("t3_busy_waiting", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk("t3_busy_fell", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // 4: bad stop bit, then a good command
        expect_evt(K_FE, 8'h00, -1);
        send_frame(8'hA5, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_rx_data_unchanged", {24'd0, rx_data}, 32'h43);
        chk("t4_not_busy", {31'd0, busy}, 32'd0);
        expect_evt(K_STB, 8'h4D, -1);
        expect_evt(K_MEAS, 8'h00, 1);
        send_frame(8'h4D, 1'b1);
        repeat (20) @(negedge clk);
        pulse_valid_check("t4_busy_after_valid");

        // 5: 3-cycle glitch is a false start
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_rx_data_unchanged", {24'd0, rx_data}, 32'h4D);
        expect_evt(K_STB, 8'h52, -1);
        expect_evt(K_STB, 8'h01, -1);
        send_frame(8'h52, 1'b1);
        send_frame(8'h01, 1'b1);
        chk("t5_resolution_after", {30'd0, resolution}, 32'd1);

        // 6: reset mid-byte while busy
        expect_evt(K_STB, 8'h4D, -1);
        expect_evt(K_MEAS, 8'h00, 1);
        send_frame(8'h4D, 1'b1);
        chk("t6_busy_before_reset", {31'd0, busy}, 32'd1);
        hold_bit(1'b0);
        for (int i = 0; i < 5; i++) hold_bit(i[0]);
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        expect_evt(K_STB, 8'h4D, -1);
        expect_evt(K_MEAS, 8'h00, 1);
        send_frame(8'h4D, 1'b1);
        repeat (20) @(negedge clk);
        pulse_valid_check("t6_busy_after_valid");
        repeat (30) @(negedge clk);
        chk("sb_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmps2_uart_cmd.md
Name: cmps2_uart_cmd

Overview:
- UART command receiver that lets a host PC drive the Pmod CMPS2 interface. It is the host-to-board counterpart of the CMPS2 tester's UART data dump.
- Deserialises 8N1 bytes from the PC and decodes single-byte commands into one-cycle measure/calibrate pulses and a resolution setting.
- Tracks completion of each measurement through the interface's valid signal, with a timeout.
- Sits between the board's UART rx pin and the cmps2 interface control inputs.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud).
- TIMEOUT_CYC, 10_000_000, max cycles to wait for valid after measure/calibrate.
- RES_DEFAULT, 2'b00, resolution value after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- rx  input  1  UART line from PC, idle high, asynchronous to clk.
- valid  input  1  measurement-valid flag from the cmps2 interface.
- measure  output  1  one-cycle measurement request pulse.
- calibrate  output  1  one-cycle calibration request pulse.
- resolution  output  2  registered resolution select.
- busy  output  1  high while waiting for valid.
- rx_data  output  8  last correctly framed byte.
- rx_strobe  output  1  one-cycle pulse when rx_data is updated.
- cmd_error  output  1  one-cycle pulse on a bad, dropped or timed-out command.
- frame_error  output  1  one-cycle pulse when the stop bit is 0.

Behaviour:
- Reset (rst low, asynchronous):
  - measure, calibrate, busy, rx_strobe, cmd_error, frame_error = 0.
  - rx_data = 0x00; resolution = RES_DEFAULT.
  - rx synchroniser flops = 1; valid edge register = 0.
  - Both FSMs return to idle. Reset mid-byte discards the partial byte.
- RX path:
  - rx passes through a 2-FF synchroniser.
  - RX FSM states: R_IDLE, R_START, R_DATA, R_STOP, R_RECOVER.
  - R_IDLE: synced rx = 0 -> R_START, bit counter cleared.
  - R_START: wait CLKS_PER_BIT/2 cycles, then re-sample. rx = 1 -> false start, back to R_IDLE with no pulse. rx = 0 -> R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - Stop = 1: rx_data loaded and rx_strobe high the next cycle, then R_IDLE.
    - Stop = 0: frame_error pulse, byte discarded, -> R_RECOVER.
  - R_RECOVER: wait for synced rx = 1, then R_IDLE.
- Command parser FSM states: P_IDLE, P_RES_ARG, P_WAIT. It acts only on rx_strobe.
- P_IDLE:
  - 0x4D ('M'): measure = 1 on the cycle after rx_strobe, -> P_WAIT.
  - 0x43 ('C'): calibrate = 1 on the cycle after rx_strobe, -> P_WAIT.
  - 0x52 ('R'): -> P_RES_ARG.
  - Any other byte: cmd_error pulse, stay in P_IDLE.
- P_RES_ARG:
  - Next byte with bits [7:2] = 0: resolution <= byte[1:0].
  - Next byte with bits [7:2] != 0: cmd_error pulse, resolution unchanged.
  - Either way -> P_IDLE.
  - A frame_error while in P_RES_ARG aborts to P_IDLE without cmd_error.
- P_WAIT:
  - busy = 1; the timeout counter clears on entry and increments each cycle.
  - valid rising edge (valid & ~valid_d) -> P_IDLE, busy = 0 the next cycle.
  - Counter reaches TIMEOUT_CYC-1 -> cmd_error pulse, -> P_IDLE.
  - Any byte received in P_WAIT is dropped with a cmd_error pulse.
- Simultaneous events:
  - valid edge and timeout in the same cycle: valid wins, no error.
  - rx_strobe and valid edge in the same cycle in P_WAIT: byte dropped with cmd_error, and the FSM still returns to P_IDLE.
- measure and calibrate are never high together. Each pulse is exactly one cycle.
- Counters: bit-period counter is clog2(CLKS_PER_BIT) bits; timeout counter is clog2(TIMEOUT_CYC) bits. Neither counter wraps: each is cleared on every state entry.

Test Plan:
(All scenarios use CLKS_PER_BIT=16, TIMEOUT_CYC=1000.)
1. Send 0x4D, raise valid 50 cycles after measure -> rx_strobe with rx_data=0x4D; measure high exactly 1 cycle, 1 cycle after rx_strobe; busy=1, then 0 the cycle after the valid edge; no cmd_error.
2. Send 0x52,0x02 then 0x52,0x07 -> resolution=2'b10 after the first pair; cmd_error pulse on 0x07 and resolution stays 2'b10.
3. Send 0x43 with valid held 0 -> calibrate pulse; cmd_error exactly 1000 cycles later; busy falls to 0.
4. Send a frame with data 0xA5 and stop bit 0 -> frame_error pulse; no rx_strobe; rx_data unchanged; no command issued; a following 0x4D still decodes.
5. Drive rx low for 3 cycles only -> no rx_strobe, no frame_error, RX FSM back in R_IDLE.
6. Assert rst low mid-byte (after bit 4) and while busy -> all outputs at reset values immediately; a full 0x4D sent after release produces a single measure pulse.
